// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson counter family.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Widest counter the HOME helper can describe; callers slice to their width.
  localparam int HOME_MAX_W = 64;

  // HOME pattern (only bit 0 set) for a counter of the given width.
  function automatic logic [HOME_MAX_W-1:0] home_of(input int width);
    logic [HOME_MAX_W-1:0] h;
    h    = '0;
    h[0] = (width > 0);
    return h;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check for one-hot ring and Johnson (twisted-ring) states.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic             illegal
);

  logic [WIDTH-1:0] thermo;
  logic             ring_ok;
  logic             johnson_ok;

  // A legal Johnson word, inverted when bit 0 is clear, is a run of ones from bit 0
  // upward (0..01..1); such a run has no bit in common with itself plus one.
  always_comb begin
    thermo     = state[0] ? state : ~state;
    ring_ok    = ($countones(state) == 1);
    johnson_ok = ((thermo & (thermo + WIDTH'(1))) == '0);
    illegal    = (mode == MODE_JOHNSON) ? !johnson_ok : !ring_ok;
  end

endmodule

// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson counter with direction, enable, parallel load,
// terminal-count pulse and optional self-correction of illegal states.
module ring_counter_gen
  import ring_counter_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             illegal
);

  localparam logic [HOME_MAX_W-1:0] HOME_WIDE = home_of(WIDTH);
  localparam logic [WIDTH-1:0]      HOME      = HOME_WIDE[WIDTH-1:0];
  // Predecessors of HOME for each mode/direction.
  localparam logic [WIDTH-1:0] TC_RING_LEFT     = HOME << (WIDTH - 1);
  localparam logic [WIDTH-1:0] TC_RING_RIGHT    = WIDTH'(2);
  localparam logic [WIDTH-1:0] TC_JOHNSON_LEFT  = '0;
  localparam logic [WIDTH-1:0] TC_JOHNSON_RIGHT = WIDTH'(3);

  logic [WIDTH-1:0] state_p0;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] tcpat;
  logic [WIDTH-1:0] next_state;

  ring_state_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .state   (state_p0),
    .mode    (mode),
    .illegal (illegal)
  );

  // Shift network and terminal-count pattern for the current mode and direction.
  always_comb begin
    shifted = state_p0;
    tcpat   = TC_RING_LEFT;
    unique case ({mode, dir})
      {MODE_RING, DIR_LEFT}: begin
        shifted = {state_p0[WIDTH-2:0], state_p0[WIDTH-1]};
        tcpat   = TC_RING_LEFT;
      end
      {MODE_RING, DIR_RIGHT}: begin
        shifted = {state_p0[0], state_p0[WIDTH-1:1]};
        tcpat   = TC_RING_RIGHT;
      end
      {MODE_JOHNSON, DIR_LEFT}: begin
        shifted = {state_p0[WIDTH-2:0], ~state_p0[WIDTH-1]};
        tcpat   = TC_JOHNSON_LEFT;
      end
      default: begin
        shifted = {~state_p0[0], state_p0[WIDTH-1:1]};
        tcpat   = TC_JOHNSON_RIGHT;
      end
    endcase
  end

  // Next-state priority: load, then self-correction, then shift, else hold.
  always_comb begin
    next_state = state_p0;
    if (load) begin
      next_state = load_val;
    end else if (en && illegal && SELF_CORRECT) begin
      next_state = HOME;
    end else if (en) begin
      next_state = shifted;
    end
  end

  // Terminal count fires on the legal step that lands on HOME.
  always_comb begin
    tc = en && !load && !illegal && !reset && (state_p0 == tcpat);
  end

  // ---- stage p0: counter state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= HOME;
    end else begin
      state_p0 <= next_state;
    end
  end

  assign out = state_p0;

endmodule

// File: doc/ring_counter_gen.md
# ring_counter_gen

Parametrised ring/Johnson counter: the next generation of the team's fixed 4-bit ring counter. Adds:
- generic width;
- run-time ring or twisted-ring (Johnson) mode;
- up/down direction, count enable and parallel load;
- terminal-count pulse;
- illegal-state detection with optional self-correction.

It serves as a sequencer and phase generator for one-hot control paths elsewhere in the design.

## Interface
- `WIDTH`, default 4: counter width in bits. Must be ≥ 2.
- `SELF_CORRECT`, default 1: when 1, an enabled step from an illegal state goes to HOME. When 0, it shifts as usual.
- `clk` input 1: single clock. All state updates on its rising edge.
- `reset` input 1: asynchronous, active-high. Forces `out` to HOME immediately.
- `en` input 1: advance one step on this clock edge.
- `mode` input 1: 0 = ring (period WIDTH), 1 = Johnson (period 2·WIDTH).
- `dir` input 1: 0 = shift left (toward MSB), 1 = shift right.
- `load` input 1: parallel load of `load_val`.
- `load_val` input WIDTH: value loaded. Not checked for legality.
- `out` output WIDTH: counter state. Registered.
- `tc` output 1: terminal count. Combinational; asserts on the step that returns `out` to HOME.
- `illegal` output 1: combinational; `out` is not a legal state for the current `mode`.

## Operation
- HOME is {0…0,1} (bit 0 set) in both modes. 0…01 is a legal Johnson state.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: `out` equals 2^k−1 or ~(2^k−1), for k = 0..WIDTH.
- Next-state rule, in priority order:
  1. `reset`: HOME.
  2. `load`: `load_val`.
  3. `en` && `illegal` && `SELF_CORRECT`: HOME.
  4. `en`: shift.
  5. Otherwise: hold.
- Shift rules:
  - Ring left: {out[W-2:0], out[W-1]}.
  - Ring right: {out[0], out[W-1:1]}.
  - Johnson left: {out[W-2:0], ~out[W-1]}.
  - Johnson right: {~out[0], out[W-1:1]}.
- `tc` = `en` && !`load` && !`illegal` && (`out` == TCPAT). TCPAT is the legal predecessor of HOME:
  - Ring left: 1 at bit W-1.
  - Ring right: 1 at bit 1.
  - Johnson left: all zeros.
  - Johnson right: 0…011.
- Changing `mode` or `dir` takes effect on the same edge. No state is kept about the previous mode.
  - A state illegal under the new mode raises `illegal` at once.
  - If self-correction is enabled, that state is corrected on the next enabled step.
- With `SELF_CORRECT`=0 the counter shifts illegal patterns verbatim and `illegal` stays asserted. Ring all-zeros stays all-zeros.
- Loading an illegal `load_val` is allowed. `illegal` asserts the cycle after the load.

## Timing
- Reset values: `out` = HOME and `illegal` = 0, asynchronously. `tc` = 0 while `reset` is high.
- Release of `reset` is sampled synchronously. The first step occurs on the first rising edge with `reset` low and `en` high.
- Latency from `en`/`load` to `out` is 1 cycle. `tc` and `illegal` are valid in the same cycle as `out`/`en`; no registered delay.
- Simultaneous `load` and `en`: `load` wins, no shift, `tc` = 0.
- `reset` asserted mid-sequence: `out` is HOME within the reset assertion, with no dependence on the clock. Any pending load or step is discarded.
- Wrap-around: ring returns to HOME every WIDTH enabled steps, Johnson every 2·WIDTH. `tc` pulses exactly once per period, on the final step.

## Structure
- Package `ring_counter_pkg` holds:
  - `MODE_RING`/`MODE_JOHNSON` and `DIR_LEFT`/`DIR_RIGHT` constants;
  - a function returning HOME for a given width.
- Sub-module `ring_state_check` (parameter WIDTH): combinational legality check. Takes `out` and `mode`, returns `illegal`. It is reused by other one-hot sequencers.
- Top level contains the next-state mux, the shift network, TCPAT compare and the state register.

## Test plan
- W=4, ring, left, `en`=1 after reset: `out` = 0001, 0010, 0100, 1000, 0001; `tc`=1 only while `out`=1000.
- W=4, Johnson, right: `out` = 0001, 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001 (period 8); `tc`=1 only at 0011.
- Load 0110 in ring, `SELF_CORRECT`=1: `illegal`=1 next cycle; next `en` gives `out`=0001 with `tc`=0. Same stimulus with `SELF_CORRECT`=0 gives `out`=1100 with `illegal` still 1.
- `load`=1, `en`=1, `load_val`=0100 while `out`=1000, ring left: `out`=0100 and `tc`=0. `en` alone with `load`=0 instead gives `out`=0001 and `tc`=1.
- At `out`=0111 in Johnson, switch `mode` to ring: `illegal`=1 in the same cycle; next `en` gives 0001.
- Assert `reset` asynchronously between edges at `out`=0100: `out` is 0001 before the next edge. W=8 ring completes 8 steps per `tc`.
